// File: rtl/phy_rx_pkg.sv
// Shared constants and types for the two-lane PHY receive synchroniser.
package phy_rx_pkg;

   localparam logic [7:0] COMMA_BC = 8'hBC;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      ACTIVE = 2'd2
   } lane_state_t;

   function automatic logic [2:0] sat_inc3(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

endpackage

// File: rtl/phy_rx_lane_sync.sv
// One serial lane: comma search, byte alignment and aligned byte delivery.
//
// state  | meaning
// SEARCH | hunting for a comma at any bit offset
// ALIGN  | byte boundary fixed, counting consecutive aligned commas
// ACTIVE | locked; non-comma bytes are strobed out, commas are idle
module phy_rx_lane_sync
   import phy_rx_pkg::*;
#(
   parameter int COMMA_COUNT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial,
   input  logic       resync,
   output logic [7:0] data,
   output logic       valid,
   output logic       active,
   output logic [2:0] bc_count
);

   localparam logic [2:0] COMMA_TARGET = 3'(COMMA_COUNT);

   lane_state_t state, state_nxt;
   logic [6:0]  sr;
   logic [7:0]  nsr;
   logic [2:0]  bit_cnt, bit_cnt_nxt;
   logic [2:0]  bc_nxt, bc_inc;
   logic [7:0]  data_nxt;
   logic        valid_nxt, active_nxt;
   logic        is_comma, boundary;

   // Decisions use the byte including the bit sampled on this edge.
   assign nsr      = {sr, serial};
   assign is_comma = (nsr == COMMA_BC);
   assign boundary = (bit_cnt == 3'd7);
   assign bc_inc   = sat_inc3(bc_count);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= SEARCH;
         sr       <= '0;
         bit_cnt  <= '0;
         bc_count <= '0;
         data     <= '0;
         valid    <= 1'b0;
         active   <= 1'b0;
      end else begin
         state    <= state_nxt;
         sr       <= nsr[6:0];
         bit_cnt  <= bit_cnt_nxt;
         bc_count <= bc_nxt;
         data     <= data_nxt;
         valid    <= valid_nxt;
         active   <= active_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt + 3'd1;
      bc_nxt      = bc_count;
      data_nxt    = data;
      valid_nxt   = 1'b0;
      active_nxt  = active;
      if (resync) begin
         state_nxt   = SEARCH;
         bit_cnt_nxt = '0;
         bc_nxt      = '0;
         active_nxt  = 1'b0;
      end else begin
         case (state)
            SEARCH: begin
               bit_cnt_nxt = '0;
               if (is_comma) begin
                  bc_nxt = 3'd1;
                  if (COMMA_TARGET <= 3'd1) begin
                     state_nxt  = ACTIVE;
                     active_nxt = 1'b1;
                  end else begin
                     state_nxt = ALIGN;
                  end
               end
            end
            ALIGN: begin
               if (boundary) begin
                  if (is_comma) begin
                     bc_nxt = bc_inc;
                     if (bc_inc >= COMMA_TARGET) begin
                        state_nxt  = ACTIVE;
                        active_nxt = 1'b1;
                     end
                  end else begin
                     state_nxt = SEARCH;
                     bc_nxt    = '0;
                  end
               end
            end
            ACTIVE: begin
               if (boundary) begin
                  if (is_comma) begin
                     bc_nxt = bc_inc;
                  end else begin
                     data_nxt  = nsr;
                     valid_nxt = 1'b1;
                  end
               end
            end
            default: begin
               state_nxt  = SEARCH;
               bc_nxt     = '0;
               active_nxt = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// Two independent lane synchronisers plus the combined lane-active flag.
module phy_rx_sync_ctrl
   import phy_rx_pkg::*;
#(
   parameter int COMMA_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       input_0,
   input  logic       input_1,
   input  logic       resync,
   output logic [7:0] data_0,
   output logic       valid_0,
   output logic [7:0] data_1,
   output logic       valid_1,
   output logic       active_0,
   output logic       active_1,
   output logic       active_all,
   output logic [2:0] BC_counter_0,
   output logic [2:0] BC_counter_1
);

   phy_rx_lane_sync #(.COMMA_COUNT(COMMA_COUNT)) u_lane_0 (
      .clk      (clk_32f),
      .rst      (reset),
      .serial   (input_0),
      .resync   (resync),
      .data     (data_0),
      .valid    (valid_0),
      .active   (active_0),
      .bc_count (BC_counter_0)
   );

   phy_rx_lane_sync #(.COMMA_COUNT(COMMA_COUNT)) u_lane_1 (
      .clk      (clk_32f),
      .rst      (reset),
      .serial   (input_1),
      .resync   (resync),
      .data     (data_1),
      .valid    (valid_1),
      .active   (active_1),
      .bc_count (BC_counter_1)
   );

   // Lane skew is not compensated; this only reports that both are locked.
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) active_all <= 1'b0;
      else       active_all <= active_0 & active_1;
   end

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Directed bench for phy_rx_sync_ctrl with a per-lane strobe scoreboard.
module tb_phy_rx_sync_ctrl;

   logic       clk_32f = 1'b0;
   logic       reset, input_0, input_1, resync;
   logic [7:0] data_0, data_1;
   logic       valid_0, valid_1, active_0, active_1, active_all;
   logic [2:0] BC_counter_0, BC_counter_1;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e_mon;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   phy_rx_sync_ctrl #(.COMMA_COUNT(4)) dut (
      .clk_32f      (clk_32f),
      .reset        (reset),
      .input_0      (input_0),
      .input_1      (input_1),
      .resync       (resync),
      .data_0       (data_0),
      .valid_0      (valid_0),
      .data_1       (data_1),
      .valid_1      (valid_1),
      .active_0     (active_0),
      .active_1     (active_1),
      .active_all   (active_all),
      .BC_counter_0 (BC_counter_0),
      .BC_counter_1 (BC_counter_1)
   );

   always #5 clk_32f = ~clk_32f;
   always @(posedge clk_32f) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b0, input logic b1);
      @(negedge clk_32f);
      input_0 = b0;
      input_1 = b1;
      @(posedge clk_32f);
      #1;
   endtask

   // Bit positions 0..7, position 0 being the MSB sent first.
   task automatic send_range(input logic [7:0] v0, input logic [7:0] v1,
                             input int first, input int last);
      for (int i = first; i <= last; i++) send_bit(v0[7-i], v1[7-i]);
   endtask

   task automatic send_byte(input logic [7:0] v0, input logic [7:0] v1);
      send_range(v0, v1, 0, 7);
   endtask

   // Every strobe must match the head of its lane queue in value and cycle.
   always @(posedge clk_32f) begin
      #1;
      if (valid_0) begin
         chk("expected_strobe_0", 32'(q0.size() != 0), 32'd1);
         if (q0.size() != 0) begin
            e_mon = q0.pop_front();
            chk("data_0", 32'(data_0), 32'(e_mon.data));
            chk("strobe_cyc_0", 32'(cyc), 32'(e_mon.cyc));
         end
      end
      if (valid_1) begin
         chk("expected_strobe_1", 32'(q1.size() != 0), 32'd1);
         if (q1.size() != 0) begin
            e_mon = q1.pop_front();
            chk("data_1", 32'(data_1), 32'(e_mon.data));
            chk("strobe_cyc_1", 32'(cyc), 32'(e_mon.cyc));
         end
      end
   end

   initial begin
      reset   = 1'b1;
      input_0 = 1'b0;
      input_1 = 1'b0;
      resync  = 1'b0;
      #12;
      chk("rst_active_0", 32'(active_0), 32'd0);
      chk("rst_active_all", 32'(active_all), 32'd0);
      chk("rst_bc_0", 32'(BC_counter_0), 32'd0);
      chk("rst_data_0", 32'(data_0), 32'd0);
      chk("rst_valid_1", 32'(valid_1), 32'd0);
      @(negedge clk_32f);
      reset = 1'b0;

      // Lock both lanes with four commas.
      send_byte(8'hBC, 8'hBC);
      chk("a_bc_0_first", 32'(BC_counter_0), 32'd1);
      send_byte(8'hBC, 8'hBC);
      send_byte(8'hBC, 8'hBC);
      send_range(8'hBC, 8'hBC, 0, 6);
      chk("a_active_0_bit31", 32'(active_0), 32'd0);
      send_range(8'hBC, 8'hBC, 7, 7);
      chk("a_active_0_bit32", 32'(active_0), 32'd1);
      chk("a_active_1_bit32", 32'(active_1), 32'd1);
      chk("a_bc_0", 32'(BC_counter_0), 32'd4);
      chk("a_bc_1", 32'(BC_counter_1), 32'd4);
      chk("a_active_all_bit32", 32'(active_all), 32'd0);
      send_range(8'hBC, 8'hBC, 0, 0);
      chk("a_active_all_bit33", 32'(active_all), 32'd1);
      send_range(8'hBC, 8'hBC, 1, 7);

      // Data bytes on both lanes, then an idle comma.
      q0.push_back('{data: 8'h5A, cyc: cyc + 8});
      q1.push_back('{data: 8'h3C, cyc: cyc + 8});
      send_byte(8'h5A, 8'h3C);
      chk("b_valid_0", 32'(valid_0), 32'd1);
      chk("b_data_0", 32'(data_0), 32'h5A);
      send_range(8'hBC, 8'hBC, 0, 0);
      chk("b_valid_0_drop", 32'(valid_0), 32'd0);
      send_range(8'hBC, 8'hBC, 1, 7);
      chk("b_data_0_hold", 32'(data_0), 32'h5A);
      chk("b_bc_0_idle", 32'(BC_counter_0), 32'd6);

      // Reset, then lane 0 locks behind three junk bits.
      reset = 1'b1;
      send_bit(1'b0, 1'b0);
      @(negedge clk_32f);
      reset = 1'b0;
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_byte(8'hBC, 8'h00);
      chk("c_lock_first_comma", 32'(BC_counter_0), 32'd1);
      send_byte(8'hBC, 8'h00);
      send_byte(8'hBC, 8'h00);
      send_range(8'hBC, 8'h00, 0, 6);
      chk("c_active_0_bit34", 32'(active_0), 32'd0);
      send_range(8'hBC, 8'h00, 7, 7);
      chk("c_active_0_bit35", 32'(active_0), 32'd1);
      chk("c_active_1_idle", 32'(active_1), 32'd0);
      chk("c_bc_1_idle", 32'(BC_counter_1), 32'd0);

      // Saturation: ten commas in total on lane 0.
      for (int i = 0; i < 6; i++) send_byte(8'hBC, 8'h00);
      chk("e_bc_0_sat", 32'(BC_counter_0), 32'd7);
      chk("e_active_0", 32'(active_0), 32'd1);

      // Lane 1 loses alignment on a non-comma.
      send_byte(8'hBC, 8'hBC);
      chk("d_bc_1_one", 32'(BC_counter_1), 32'd1);
      send_byte(8'hBC, 8'hBC);
      chk("d_bc_1_two", 32'(BC_counter_1), 32'd2);
      send_byte(8'hBC, 8'h12);
      chk("d_bc_1_cleared", 32'(BC_counter_1), 32'd0);
      chk("d_active_1", 32'(active_1), 32'd0);

      // Relock lane 1, then an asynchronous reset in mid-byte.
      for (int i = 0; i < 4; i++) send_byte(8'hBC, 8'hBC);
      chk("f_active_1", 32'(active_1), 32'd1);
      send_range(8'hBC, 8'hBC, 0, 2);
      chk("f_active_all_pre", 32'(active_all), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("f_arst_active_0", 32'(active_0), 32'd0);
      chk("f_arst_active_1", 32'(active_1), 32'd0);
      chk("f_arst_active_all", 32'(active_all), 32'd0);
      chk("f_arst_bc_0", 32'(BC_counter_0), 32'd0);
      chk("f_arst_bc_1", 32'(BC_counter_1), 32'd0);
      @(negedge clk_32f);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) send_byte(8'hBC, 8'hBC);
      chk("f_relock_3", 32'(active_0), 32'd0);
      send_byte(8'hBC, 8'hBC);
      chk("f_relock_4_0", 32'(active_0), 32'd1);
      chk("f_relock_4_1", 32'(active_1), 32'd1);
      send_byte(8'hBC, 8'hBC);

      // Resync on the final bit of a comma must win over the match.
      send_range(8'hBC, 8'hBC, 0, 6);
      resync = 1'b1;
      send_range(8'hBC, 8'hBC, 7, 7);
      resync = 1'b0;
      chk("g_resync_active_0", 32'(active_0), 32'd0);
      chk("g_resync_active_1", 32'(active_1), 32'd0);
      chk("g_resync_bc_0", 32'(BC_counter_0), 32'd0);
      chk("g_resync_bc_1", 32'(BC_counter_1), 32'd0);
      send_range(8'hBC, 8'hBC, 0, 0);
      chk("g_active_all_drop", 32'(active_all), 32'd0);
      send_range(8'hBC, 8'hBC, 1, 7);
      chk("g_bc_0_new", 32'(BC_counter_0), 32'd1);
      send_byte(8'hBC, 8'hBC);
      send_byte(8'hBC, 8'hBC);
      chk("g_relock_3", 32'(active_1), 32'd0);
      send_byte(8'hBC, 8'hBC);
      chk("g_relock_4", 32'(active_1), 32'd1);

      send_byte(8'hBC, 8'hBC);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/phy_rx_sync_ctrl.md
Name: phy_rx_sync_ctrl

Overview:
Receive-side lane synchronisation controller for the two-lane serial PHY receiver. For each serial lane it finds the 8'hBC comma, locks byte alignment, and declares the lane active after COMMA_COUNT consecutive aligned commas. Once a lane is active, it delivers each aligned non-comma byte with a valid strobe. It sits between the serial inputs (input_0/input_1) and the parallel packing stage, and sequences that stage through active_0/1 and active_all.

Parameters:
COMMA, 8'hBC, comma/idle byte; serial order is MSB first.
COMMA_COUNT, 4, consecutive aligned commas required to enter ACTIVE (range 1..7).

Ports:
clk_32f  input  1  serial bit clock; all logic on the posedge.
reset  input  1  asynchronous, active-high reset.
input_0  input  1  serial data, lane 0.
input_1  input  1  serial data, lane 1.
resync  input  1  synchronous; forces both lanes back to SEARCH.
data_0  output  8  aligned byte, lane 0.
valid_0  output  1  one-cycle strobe; data_0 holds a new data byte.
data_1  output  8  aligned byte, lane 1.
valid_1  output  1  one-cycle strobe, lane 1.
active_0  output  1  lane 0 is in ACTIVE.
active_1  output  1  lane 1 is in ACTIVE.
active_all  output  1  active_0 & active_1, registered.
BC_counter_0  output  3  commas seen by lane 0 since leaving SEARCH; saturates at 7.
BC_counter_1  output  3  same, lane 1.

Behaviour:
- Reset value of every register and output is 0; every lane FSM resets to SEARCH.
- Per lane, each edge computes nsr = {sr[6:0], input_x}, and sr <= nsr. All decisions below use nsr, so a byte is judged on the edge that samples its 8th bit.
- SEARCH:
  - Every edge, if nsr == COMMA: go to ALIGN, bit_cnt <= 0, BC_counter <= 1.
  - If COMMA_COUNT == 1, go straight to ACTIVE instead.
- ALIGN:
  - bit_cnt increments each edge and wraps 7 -> 0.
  - A byte boundary is the edge where bit_cnt == 7.
  - At a boundary, nsr == COMMA: BC_counter increments (saturating at 7). If the new count >= COMMA_COUNT, go to ACTIVE.
  - At a boundary, nsr != COMMA: go to SEARCH and clear BC_counter to 0.
- ACTIVE:
  - At a boundary, nsr == COMMA is idle: valid stays 0 and BC_counter increments (saturating).
  - At a boundary, nsr != COMMA: data_x <= nsr and valid_x <= 1 for exactly one cycle.
  - data_x holds its value between strobes.
- active_x is registered and rises on the same edge the FSM enters ACTIVE. active_all follows one cycle later.
- The byte-to-strobe latency is 0 extra cycles: the strobe appears on the edge that samples the byte's last bit.
- resync = 1 (synchronous): both lanes go to SEARCH and clear bit_cnt, BC_counter, valid and active on that edge. sr still shifts.
- Reset asserted mid-operation clears everything immediately (asynchronous); reset dominates resync.
- Lanes are fully independent. Lane skew is not compensated in this block.
- valid_x is never asserted outside ACTIVE.
- In SEARCH, overlapping comma matches are allowed: the first match wins.

Decomposition:
- Shared package phy_rx_pkg:
  - COMMA_BC = 8'hBC
  - lane state encoding SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2
- Sub-module phy_rx_lane_sync, instantiated twice. It contains sr, bit_cnt, the FSM, BC_counter, data, valid and active for one lane.
- The top level adds only the resync fan-out and the active_all register.

Test Plan:
- 4 x 0xBC MSB-first on both lanes after reset release:
  - active_0/1 rise on the edge sampling bit 32.
  - BC_counter = 4.
  - active_all rises one edge later.
  - valid stays 0 throughout.
- Lane 0 is ACTIVE, then byte 0x5A:
  - data_0 = 0x5A and valid_0 = 1 for exactly one cycle, on the edge sampling the 8th bit.
  - A following 0xBC produces no strobe.
- Lane 0 gets 3 junk bits (1,1,0), then 4 x 0xBC:
  - Lock occurs at the first 0xBC.
  - active_0 rises on the edge sampling the 35th bit.
- Sequence 0xBC, 0xBC, 0x12 on lane 1:
  - Lane 1 returns to SEARCH at the 0x12 boundary.
  - BC_counter_1 = 0 and active_1 stays 0.
- 10 x 0xBC on lane 0: BC_counter_0 saturates at 7 and active_0 stays 1.
- Both lanes ACTIVE, then reset mid-byte, then resync after relock:
  - Reset asynchronously clears all outputs to 0.
  - After relock, resync drops active_0/1 and BC_counters to 0 on the next edge.
  - Relock requires 4 new commas.
